// File: rtl/ex_mem_stage_if.sv
// EX->MEM handshake bundle: execute-side beat inputs, memory-side head outputs, forwarding taps.
// slave = the pipeline stage; master = whoever drives the execute side and consumes the head.
interface ex_mem_stage_if #(
    parameter int REGSIZE = 64,
    parameter int RADDR   = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [REGSIZE-1:0] alu_out;
    logic               alu_nz;
    logic [REGSIZE-1:0] store_data;
    logic [REGSIZE-1:0] branch_target;
    logic [RADDR-1:0]   rd;
    logic               ctl_mem_read;
    logic               ctl_mem_write;
    logic               ctl_reg_write;
    logic               ctl_mem_to_reg;
    logic               ctl_cbz;
    logic               ctl_ubranch;
    logic               flush;

    logic               out_valid;
    logic               out_ready;
    logic [REGSIZE-1:0] out_alu;
    logic [REGSIZE-1:0] out_store;
    logic [REGSIZE-1:0] out_target;
    logic [RADDR-1:0]   out_rd;
    logic               out_mem_read;
    logic               out_mem_write;
    logic               out_reg_write;
    logic               out_mem_to_reg;
    logic               out_pc_src;
    logic               fwd_valid;
    logic [RADDR-1:0]   fwd_rd;
    logic [REGSIZE-1:0] fwd_data;

    modport slave (
        input  in_valid, alu_out, alu_nz, store_data, branch_target, rd,
               ctl_mem_read, ctl_mem_write, ctl_reg_write, ctl_mem_to_reg,
               ctl_cbz, ctl_ubranch, flush, out_ready,
        output in_ready, out_valid, out_alu, out_store, out_target, out_rd,
               out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
               out_pc_src, fwd_valid, fwd_rd, fwd_data
    );

    modport master (
        output in_valid, alu_out, alu_nz, store_data, branch_target, rd,
               ctl_mem_read, ctl_mem_write, ctl_reg_write, ctl_mem_to_reg,
               ctl_cbz, ctl_ubranch, flush, out_ready,
        input  in_ready, out_valid, out_alu, out_store, out_target, out_rd,
               out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg,
               out_pc_src, fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/ex_mem_stage.sv
// LEGv8 EX->MEM register with CBZ/B resolution; 1-cycle latency, 1 beat/cycle.
// Two-entry skid (main + skid) absorbs one stall; in_ready drops only once full, never from out_ready.
module ex_mem_stage #(
    parameter int REGSIZE = 64,
    parameter int RADDR   = 5
) (
    input  logic             clk,
    input  logic             reset,
    ex_mem_stage_if.slave    bus
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    typedef struct packed {
        logic [REGSIZE-1:0] alu;
        logic [REGSIZE-1:0] store;
        logic [REGSIZE-1:0] target;
        logic [RADDR-1:0]   rd;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
        logic               taken;
    } entry_t;

    logic [1:0] r_state;
    logic       r_main_vld;
    entry_t     r_main;
    entry_t     r_skid;

    entry_t     w_new;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_pop;

    // Branch resolved and XZR writes dropped here so the head is final once stored.
    always_comb begin
        w_new            = '0;
        w_new.alu        = bus.alu_out;
        w_new.store      = bus.store_data;
        w_new.target     = bus.branch_target;
        w_new.rd         = bus.rd;
        w_new.mem_read   = bus.ctl_mem_read;
        w_new.mem_write  = bus.ctl_mem_write;
        w_new.reg_write  = bus.ctl_reg_write & (bus.rd != RADDR'(31));
        w_new.mem_to_reg = bus.ctl_mem_to_reg;
        w_new.taken      = bus.ctl_ubranch | (bus.ctl_cbz & ~bus.alu_nz);
    end

    assign w_in_ready = ~reset & (r_state != S_FULL) & ~bus.flush;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_pop      = r_main_vld & bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_main_vld <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else if (bus.flush) begin
            r_state    <= S_EMPTY;
            r_main_vld <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_main     <= w_new;
                        r_main_vld <= 1'b1;
                        r_state    <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_pop) begin
                        r_main <= w_new;
                    end else if (w_accept) begin
                        r_skid  <= w_new;
                        r_state <= S_FULL;
                    end else if (w_pop) begin
                        r_main_vld <= 1'b0;
                        r_state    <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_state <= S_ONE;
                    end
                end
                default: begin
                    r_state    <= S_EMPTY;
                    r_main_vld <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = r_main_vld;
    assign bus.out_alu        = r_main.alu;
    assign bus.out_store      = r_main.store;
    assign bus.out_target     = r_main.target;
    assign bus.out_rd         = r_main.rd;
    assign bus.out_mem_read   = r_main.mem_read;
    assign bus.out_mem_write  = r_main.mem_write;
    assign bus.out_reg_write  = r_main.reg_write;
    assign bus.out_mem_to_reg = r_main.mem_to_reg;
    assign bus.out_pc_src     = r_main_vld & r_main.taken;
    assign bus.fwd_valid      = r_main_vld & r_main.reg_write & ~r_main.mem_to_reg;
    assign bus.fwd_rd         = r_main.rd;
    assign bus.fwd_data       = r_main.alu;
endmodule
